// File: rtl/sim_tick_pkg.sv
// Shared types and constants for the HIL simulation timebase.
package sim_tick_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2
    } state_t;

    localparam int FAST_DIV_DEF   = 500;
    localparam int SLOW_RATIO_DEF = 100;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Modulo-DIV counter that advances while enabled and emits a registered
// one-cycle pulse on the cycle after it wraps.
module tick_prescaler
    import sim_tick_pkg::*;
#(
    parameter int DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_wrap
);

    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_count;
    logic          r_wrap;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign o_wrap    = r_wrap;

    // Holding the count while disabled keeps the phase across pauses.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= i_en && w_at_last;
            if (i_en) begin
                r_count <= w_at_last ? '0 : r_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/sim_tick_scheduler.sv
// Run/stop/step controlled fast and slow tick generator with a tick/ack
// handshake towards the sim engine and a sticky overrun flag.
module sim_tick_scheduler
    import sim_tick_pkg::*;
#(
    parameter int FAST_DIV   = FAST_DIV_DEF,
    parameter int SLOW_RATIO = SLOW_RATIO_DEF,
    parameter int STEP_W     = 16
) (
    input  logic              i_clk_50Mhz,
    input  logic              i_rst,
    input  logic              i_cmd_run,
    input  logic              i_cmd_stop,
    input  logic              i_cmd_step,
    input  logic [STEP_W-1:0] i_step_count,
    input  logic              i_sim_ack,
    output logic              o_fast_tick,
    output logic              o_slow_tick,
    output logic              o_running,
    output logic              o_sim_pending,
    output logic              o_overrun,
    output logic [31:0]       o_tick_count
);

    state_t            r_state;
    state_t            w_next_state;
    logic [STEP_W-1:0] r_remaining;
    logic [STEP_W-1:0] w_next_remaining;
    logic              w_clear_overrun;
    logic              r_running;
    logic              r_fast_tick;
    logic              r_sim_pending;
    logic              r_overrun;
    logic [31:0]       r_tick_count;
    logic              w_fast_wrap;
    logic              w_slow_wrap;

    tick_prescaler #(.DIV(FAST_DIV)) u_fast_prescaler (
        .i_clk  (i_clk_50Mhz),
        .i_rst  (i_rst),
        .i_en   (r_running),
        .o_wrap (w_fast_wrap)
    );

    // The slow divider advances on the same edge that raises fast_tick,
    // so its pulse lines up with the matching fast_tick.
    tick_prescaler #(.DIV(SLOW_RATIO)) u_slow_divider (
        .i_clk  (i_clk_50Mhz),
        .i_rst  (i_rst),
        .i_en   (w_fast_wrap),
        .o_wrap (w_slow_wrap)
    );

    always_ff @(posedge i_clk_50Mhz) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_remaining <= '0;
            r_running   <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_remaining <= w_next_remaining;
            r_running   <= (w_next_state != IDLE);
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_remaining = r_remaining;
        w_clear_overrun  = 1'b0;
        case (r_state)
            IDLE: begin
                if (!i_cmd_stop) begin
                    if (i_cmd_run) begin
                        w_next_state    = RUN;
                        w_clear_overrun = 1'b1;
                    end else if (i_cmd_step && (i_step_count != '0)) begin
                        w_next_state     = STEP;
                        w_next_remaining = i_step_count;
                    end
                end
            end
            RUN: begin
                if (i_cmd_stop) begin
                    w_next_state = IDLE;
                end
            end
            STEP: begin
                // Step budget is consumed on the edge that raises fast_tick.
                if (i_cmd_stop) begin
                    w_next_state     = IDLE;
                    w_next_remaining = '0;
                end else if (i_cmd_run) begin
                    w_next_state     = RUN;
                    w_next_remaining = '0;
                end else if (w_fast_wrap) begin
                    if (r_remaining == STEP_W'(1)) begin
                        w_next_state     = IDLE;
                        w_next_remaining = '0;
                    end else begin
                        w_next_remaining = r_remaining - STEP_W'(1);
                    end
                end
            end
            default: begin
                w_next_state     = IDLE;
                w_next_remaining = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk_50Mhz) begin
        if (i_rst) begin
            r_fast_tick   <= 1'b0;
            r_sim_pending <= 1'b0;
            r_overrun     <= 1'b0;
            r_tick_count  <= '0;
        end else begin
            r_fast_tick <= w_fast_wrap;
            if (r_fast_tick) begin
                r_tick_count  <= r_tick_count + 32'd1;
                r_sim_pending <= 1'b1;
            end else if (i_sim_ack) begin
                r_sim_pending <= 1'b0;
            end
            if (r_fast_tick && r_sim_pending && !i_sim_ack) begin
                r_overrun <= 1'b1;
            end else if (w_clear_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_fast_tick   = r_fast_tick;
    assign o_slow_tick   = w_slow_wrap;
    assign o_running     = r_running;
    assign o_sim_pending = r_sim_pending;
    assign o_overrun     = r_overrun;
    assign o_tick_count  = r_tick_count;

endmodule

// File: tb/tb_sim_tick_scheduler.sv
// Bench for sim_tick_scheduler: a vector table, hand-written corner
// sequences and a randomized run against a behavioural model.
module tb_sim_tick_scheduler;

    localparam int FAST_DIV   = 4;
    localparam int SLOW_RATIO = 3;
    localparam int STEP_W     = 16;

    logic              clk;
    logic              rst;
    logic              cmdRun;
    logic              cmdStop;
    logic              cmdStep;
    logic [STEP_W-1:0] stepCount;
    logic              simAck;
    logic              fastTick;
    logic              slowTick;
    logic              running;
    logic              simPending;
    logic              overrun;
    logic [31:0]       tickCount;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        run;
        logic        stop;
        logic        step;
        logic [15:0] cnt;
        logic        ack;
        logic        expFast;
        logic        expSlow;
        logic        expRun;
        logic        expPend;
        logic        expOvr;
        logic [31:0] expCount;
    } vec_t;

    vec_t vecs[27];

    int          mMode;
    int          mLeft;
    int          mPhase;
    int          mTickAt;
    int          mIssued;
    int          edgeNum;
    logic [31:0] mCount;
    logic        mPend;
    logic        mOvr;
    logic        mFast;
    logic        mSlow;
    logic        mRun;

    sim_tick_scheduler #(
        .FAST_DIV   (FAST_DIV),
        .SLOW_RATIO (SLOW_RATIO),
        .STEP_W     (STEP_W)
    ) dut (
        .i_clk_50Mhz   (clk),
        .i_rst         (rst),
        .i_cmd_run     (cmdRun),
        .i_cmd_stop    (cmdStop),
        .i_cmd_step    (cmdStep),
        .i_step_count  (stepCount),
        .i_sim_ack     (simAck),
        .o_fast_tick   (fastTick),
        .o_slow_tick   (slowTick),
        .o_running     (running),
        .o_sim_pending (simPending),
        .o_overrun     (overrun),
        .o_tick_count  (tickCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: ticks follow every FAST_DIV-th running cycle by one edge; mode
    // and handshake rules applied directly from the behaviour description.
    task automatic modelEdge(input logic run, input logic stop, input logic step,
                             input logic [15:0] cnt, input logic ack, input logic rs);
        logic issue;
        logic oldFast;
        logic oldRun;
        logic setOvr;
        logic clearOvr;
        if (rs) begin
            mMode = 0; mLeft = 0; mPhase = 0; mTickAt = -1; mIssued = 0;
            mCount = 0; mPend = 0; mOvr = 0; mFast = 0; mSlow = 0; mRun = 0;
        end else begin
            oldFast  = mFast;
            oldRun   = mRun;
            issue    = (mTickAt == edgeNum);
            mFast    = issue;
            if (issue) mIssued++;
            mSlow    = issue && ((mIssued % SLOW_RATIO) == 0);
            if (oldRun) begin
                mPhase = (mPhase + 1) % FAST_DIV;
                if (mPhase == 0) mTickAt = edgeNum + 1;
            end
            if (oldFast) mCount = mCount + 1;
            setOvr   = oldFast && mPend && !ack;
            if (oldFast) mPend = 1;
            else if (ack) mPend = 0;
            clearOvr = 0;
            case (mMode)
                0: if (!stop) begin
                       if (run) begin mMode = 1; clearOvr = 1; end
                       else if (step && cnt != 0) begin mMode = 2; mLeft = cnt; end
                   end
                1: if (stop) mMode = 0;
                default: begin
                    if (stop) begin mMode = 0; mLeft = 0; end
                    else if (run) begin mMode = 1; mLeft = 0; end
                    else if (issue) begin
                        if (mLeft == 1) begin mMode = 0; mLeft = 0; end
                        else mLeft--;
                    end
                end
            endcase
            if (clearOvr) mOvr = 0;
            if (setOvr) mOvr = 1;
            mRun = (mMode != 0);
        end
        edgeNum++;
    endtask

    task automatic applyStimulus(input logic run, input logic stop, input logic step,
                                 input logic [15:0] cnt, input logic ack, input logic rs);
        cmdRun    = run;
        cmdStop   = stop;
        cmdStep   = step;
        stepCount = cnt;
        simAck    = ack;
        rst       = rs;
        @(posedge clk);
        modelEdge(run, stop, step, cnt, ack, rs);
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic f, input logic s,
                               input logic r, input logic p, input logic o,
                               input logic [31:0] c);
        checks++;
        if ({fastTick, slowTick, running, simPending, overrun, tickCount} !== {f, s, r, p, o, c}) begin
            errors++;
            $display("[TB] FAIL %s actual fast=%b slow=%b run=%b pend=%b ovr=%b cnt=%0d expected fast=%b slow=%b run=%b pend=%b ovr=%b cnt=%0d",
                     name, fastTick, slowTick, running, simPending, overrun, tickCount, f, s, r, p, o, c);
        end
    endtask

    task automatic checkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
        end
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 0, 16'd0, 0, 1);
    endtask

    initial begin
        int nTicks;
        edgeNum = 0;
        nTicks  = 0;

        // Free-run from fresh reset with no acks: ticks every FAST_DIV
        // cycles after the first, slow on every third tick.
        for (int k = 0; k < 27; k++) begin
            vecs[k].run      = (k == 0);
            vecs[k].stop     = 1'b0;
            vecs[k].step     = 1'b0;
            vecs[k].cnt      = 16'd0;
            vecs[k].ack      = 1'b0;
            vecs[k].expFast  = (k == 5 || k == 9 || k == 13 || k == 17 || k == 21 || k == 25);
            vecs[k].expSlow  = (k == 13 || k == 25);
            vecs[k].expRun   = 1'b1;
            vecs[k].expPend  = (k >= 6);
            vecs[k].expOvr   = (k >= 10);
            vecs[k].expCount = nTicks;
            if (vecs[k].expFast) nTicks++;
        end

        doReset();
        doReset();
        checkOutput("reset", 0, 0, 0, 0, 0, 0);

        for (int k = 0; k < 27; k++) begin
            applyStimulus(vecs[k].run, vecs[k].stop, vecs[k].step, vecs[k].cnt, vecs[k].ack, 0);
            checkOutput($sformatf("vec%0d", k), vecs[k].expFast, vecs[k].expSlow, vecs[k].expRun,
                        vecs[k].expPend, vecs[k].expOvr, vecs[k].expCount);
        end

        // Two-tick step from IDLE.
        doReset();
        for (int k = 0; k < 30; k++) begin
            applyStimulus(0, 0, k == 0, 16'd2, 0, 0);
            checkBit($sformatf("step2_fast%0d", k), fastTick, k == 5 || k == 9);
            checkBit($sformatf("step2_run%0d", k), running, k < 9);
        end

        // Zero-length step is a no-op; run beats step in the same cycle.
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 0, k == 0, 16'd0, 0, 0);
            checkBit($sformatf("step0_run%0d", k), running, 1'b0);
            checkBit($sformatf("step0_fast%0d", k), fastTick, 1'b0);
        end
        for (int k = 0; k < 18; k++) begin
            applyStimulus(k == 0, 0, k == 0, 16'd3, 0, 0);
            checkBit($sformatf("runstep_run%0d", k), running, 1'b1);
            checkBit($sformatf("runstep_fast%0d", k), fastTick, k == 5 || k == 9 || k == 13 || k == 17);
        end

        // Pause mid-period keeps fast and slow phase.
        doReset();
        for (int k = 0; k < 31; k++) begin
            applyStimulus(k == 0 || k == 16, k >= 6 && k <= 15, 0, 16'd0, 0, 0);
            checkBit($sformatf("pause_fast%0d", k), fastTick, k == 5 || k == 19 || k == 23 || k == 27);
            checkBit($sformatf("pause_slow%0d", k), slowTick, k == 23);
            checkBit($sformatf("pause_run%0d", k), running, k < 6 || k >= 16);
        end

        // Handshake and overrun.
        doReset();
        for (int k = 0; k < 27; k++) begin
            applyStimulus(k == 0 || k == 24, k == 23, 0, 16'd0,
                          k == 6 || k == 8 || k == 14 || k == 22, 0);
            checkBit($sformatf("hs_fast%0d", k), fastTick,
                     k == 5 || k == 9 || k == 13 || k == 17 || k == 21 || k == 26);
            checkBit($sformatf("hs_pend%0d", k), simPending, (k >= 6 && k <= 7) || k >= 10);
            checkBit($sformatf("hs_ovr%0d", k), overrun, k >= 18 && k <= 23);
        end

        // Reset in the middle of a step.
        doReset();
        for (int k = 0; k < 11; k++) begin
            applyStimulus(0, 0, k == 0, 16'd7, 0, 0);
        end
        checkOutput("midstep", 0, 0, 1, 1, 1, 2);
        applyStimulus(0, 0, 0, 16'd0, 0, 1);
        checkOutput("midstep_rst", 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 0, 0, 16'd0, 0, 0);
            checkOutput($sformatf("post_rst%0d", k), 0, 0, 0, 0, 0, 0);
        end

        // Randomized commands against the model.
        doReset();
        for (int n = 0; n < 3000; n++) begin
            applyStimulus($urandom_range(0, 14) == 0, $urandom_range(0, 19) == 0,
                          $urandom_range(0, 11) == 0, 16'($urandom_range(0, 5)),
                          $urandom_range(0, 2) == 0, $urandom_range(0, 255) == 0);
            checkOutput($sformatf("rand%0d", n), mFast, mSlow, mRun, mPend, mOvr, mCount);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
